// File: rtl/sequencer.sv
// 4-bit accumulator-style sequencer: 16x8 program memory, IDLE/FETCH/EXEC control,
// two data registers, an output latch and a carry flag. Each instruction takes two cycles.
module sequencer (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_wdata,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic [3:0] pc,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry,
    output logic [1:0] state,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] prog_mem [16];
    logic [7:0] ir_reg;
    logic [3:0] pc_reg, pc_next;
    logic [3:0] a_reg, a_next;
    logic [3:0] b_reg, b_next;
    logic [3:0] out_reg, out_next;
    logic       carry_reg, carry_next;
    logic       mem_we, ir_load, retire;
    logic [3:0] opcode, imm, operand, addend;
    logic [1:0] sel;
    logic       is_add;
    logic [4:0] sum;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            IDLE: begin
                mem_we = prog_we;
                if (run || step) state_next = FETCH;
            end
            FETCH: begin
                ir_load    = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                retire     = 1'b1;
                state_next = run ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Program memory is never reset; its registered read port is the IR.
    always_ff @(posedge clk0) begin
        if (mem_we) prog_mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n)       ir_reg <= '0;
        else if (ir_load) ir_reg <= prog_mem[pc_reg];
    end

    assign opcode = ir_reg[7:4];
    assign imm    = ir_reg[3:0];
    // Operand selector falls out of the low opcode bits: 11=A, 10=B, 01=in_port, 00=zero.
    assign sel    = ~opcode[1:0];
    assign is_add = (opcode == 4'b0000) || (opcode == 4'b0101);

    always_comb begin
        case (sel)
            2'b11:   operand = a_reg;
            2'b10:   operand = b_reg;
            2'b01:   operand = in_port;
            default: operand = 4'd0;
        endcase
    end

    // Only ADDs and immediate loads take the immediate; plain moves pass the operand through.
    assign addend = (is_add || sel == 2'b00) ? imm : 4'd0;
    assign sum    = {1'b0, operand} + {1'b0, addend};

    always_comb begin
        pc_next    = pc_reg + 4'd1;
        a_next     = a_reg;
        b_next     = b_reg;
        out_next   = out_reg;
        carry_next = is_add ? sum[4] : 1'b0;
        casez (opcode)
            4'b00??:        a_next   = sum[3:0];
            4'b01??:        b_next   = sum[3:0];
            4'b1001,
            4'b1011:        out_next = sum[3:0];
            4'b1110:        if (!carry_reg) pc_next = imm;
            4'b1111:        pc_next  = imm;
            default:        ;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (retire) begin
            pc_reg    <= pc_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            out_reg   <= out_next;
            carry_reg <= carry_next;
        end
    end

    assign out_port = out_reg;
    assign pc       = pc_reg;
    assign reg_a    = a_reg;
    assign reg_b    = b_reg;
    assign carry    = carry_reg;
    assign state    = state_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: instruction-level reference model checked every cycle,
// plus directed programs with hand-computed expectations.
module tb_sequencer;
    logic       clk0 = 1'b0;
    logic       rst_n = 1'b1;
    logic       run, step, prog_we;
    logic [3:0] prog_addr, in_port;
    logic [7:0] prog_wdata;
    logic [3:0] out_port, pc, reg_a, reg_b;
    logic       carry, busy;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    sequencer dut (
        .clk0(clk0), .rst_n(rst_n), .run(run), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .in_port(in_port), .out_port(out_port), .pc(pc), .reg_a(reg_a),
        .reg_b(reg_b), .carry(carry), .state(state), .busy(busy)
    );

    always #5 clk0 = ~clk0;

    // Reference model: phase 0 idle, 1 fetch, 2 execute; one whole instruction per execute.
    typedef struct {
        int phase;
        int pc;
        int a;
        int b;
        int out;
        int c;
    } model_t;

    model_t     m = '{default: 0};
    logic [7:0] m_mem [16];

    function automatic model_t exec1(model_t cur, logic [7:0] word, logic [3:0] inp, logic go);
        model_t n;
        int     imm;
        int     s;
        n     = cur;
        imm   = int'(word[3:0]);
        n.c   = 0;
        n.pc  = (cur.pc + 1) % 16;
        case (int'(word[7:4]))
            0:  begin s = cur.a + imm; n.a = s % 16; n.c = (s > 15) ? 1 : 0; end
            1:  n.a = cur.b;
            2:  n.a = int'(inp);
            3:  n.a = imm;
            4:  n.b = cur.a;
            5:  begin s = cur.b + imm; n.b = s % 16; n.c = (s > 15) ? 1 : 0; end
            6:  n.b = int'(inp);
            7:  n.b = imm;
            9:  n.out = cur.b;
            11: n.out = imm;
            14: if (cur.c == 0) n.pc = imm;
            15: n.pc = imm;
            default: ;
        endcase
        n.phase = go ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{default: 0};
        end else begin
            case (m.phase)
                0: begin
                    if (prog_we) m_mem[prog_addr] <= prog_wdata;
                    if (run || step) m.phase <= 1;
                end
                1:       m.phase <= 2;
                default: m <= exec1(m, m_mem[m.pc[3:0]], in_port, run);
            endcase
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed value pinned against both the DUT and the model.
    task automatic lit(input string name, input logic [7:0] act, input int mod, input logic [7:0] exp);
        check(name, act, exp);
        check({name, "_model"}, 8'(mod), exp);
    endtask

    always @(negedge clk0) begin
        if (rst_n && cmp_en) begin
            check("cyc_state", 8'(state), 8'(m.phase));
            check("cyc_busy",  8'(busy),  8'(m.phase != 0));
            check("cyc_pc",    8'(pc),    8'(m.pc));
            check("cyc_a",     8'(reg_a), 8'(m.a));
            check("cyc_b",     8'(reg_b), 8'(m.b));
            check("cyc_out",   8'(out_port), 8'(m.out));
            check("cyc_carry", 8'(carry), 8'(m.c));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic load(input logic [3:0] addr, input logic [7:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_wdata = data;
        cyc(1);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        run = 0; step = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0; in_port = 0;
        #2 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        lit("rst_state", 8'(state), m.phase, 8'h00);
        lit("rst_busy", 8'(busy), int'(m.phase != 0), 8'h00);
        lit("rst_pc", 8'(pc), m.pc, 8'h00);
        lit("rst_a", 8'(reg_a), m.a, 8'h00);
        lit("rst_carry", 8'(carry), m.c, 8'h00);
        cmp_en = 1'b1;
        for (int i = 0; i < 16; i++) load(4'(i), 8'h80);
        cyc(3);
        lit("idle_hold_state", 8'(state), m.phase, 8'h00);

        // Add with carry out, JNC not taken, OUT immediate
        do_reset();
        load(4'h0, 8'h3F); load(4'h1, 8'h01); load(4'h2, 8'hE5); load(4'h3, 8'hB7);
        run = 1;
        cyc(5);
        lit("add_a", 8'(reg_a), m.a, 8'h00);
        lit("add_carry", 8'(carry), m.c, 8'h01);
        cyc(2);
        lit("jnc_nt_pc", 8'(pc), m.pc, 8'h03);
        lit("jnc_nt_carry", 8'(carry), m.c, 8'h00);
        cyc(2);
        lit("out_imm", 8'(out_port), m.out, 8'h07);
        run = 0;
        cyc(4);

        // JNC taken
        do_reset();
        load(4'h0, 8'h31); load(4'h1, 8'hE4); load(4'h4, 8'hBA);
        run = 1;
        cyc(3);
        lit("mov_a1", 8'(reg_a), m.a, 8'h01);
        cyc(2);
        lit("jnc_t_pc", 8'(pc), m.pc, 8'h04);
        cyc(2);
        lit("out_a", 8'(out_port), m.out, 8'h0A);
        run = 0;
        cyc(4);

        // Single step
        do_reset();
        load(4'h0, 8'h3F); load(4'h1, 8'h01); load(4'h2, 8'hE5); load(4'h3, 8'hB7);
        step = 1;
        cyc(1);
        lit("step_fetch", 8'(state), m.phase, 8'h01);
        step = 0;
        cyc(1);
        lit("step_exec", 8'(state), m.phase, 8'h02);
        cyc(1);
        lit("step_idle", 8'(state), m.phase, 8'h00);
        lit("step_a", 8'(reg_a), m.a, 8'h0F);
        lit("step_pc", 8'(pc), m.pc, 8'h01);
        cyc(4);
        lit("step_hold_pc", 8'(pc), m.pc, 8'h01);
        lit("step_hold_busy", 8'(busy), int'(m.phase != 0), 8'h00);

        // Write attempted outside IDLE is dropped
        do_reset();
        run = 1;
        cyc(2);
        lit("we_exec_state", 8'(state), m.phase, 8'h02);
        prog_we = 1; prog_addr = 4'h0; prog_wdata = 8'h00;
        cyc(2);
        prog_we = 0; run = 0;
        cyc(3);
        do_reset();
        step = 1;
        cyc(1);
        step = 0;
        cyc(2);
        lit("we_ignored_a", 8'(reg_a), m.a, 8'h0F);

        // Write and run on the same IDLE edge: new word is fetched
        do_reset();
        prog_we = 1; prog_addr = 4'h0; prog_wdata = 8'h00; run = 1;
        cyc(1);
        prog_we = 0;
        lit("we_run_state", 8'(state), m.phase, 8'h01);
        cyc(2);
        lit("we_run_a", 8'(reg_a), m.a, 8'h00);
        lit("we_run_pc", 8'(pc), m.pc, 8'h01);
        run = 0;
        cyc(4);

        // JMP to 15, then increment wraps pc to 0
        do_reset();
        load(4'h0, 8'hFF); load(4'hF, 8'h00);
        run = 1;
        cyc(3);
        lit("jmp_pc", 8'(pc), m.pc, 8'h0F);
        cyc(2);
        lit("wrap_pc", 8'(pc), m.pc, 8'h00);
        lit("wrap_carry", 8'(carry), m.c, 8'h00);
        run = 0;
        cyc(4);

        // Remaining opcodes, in_port and NOPs
        do_reset();
        load(4'h0, 8'h20); load(4'h1, 8'h40); load(4'h2, 8'h58); load(4'h3, 8'hE9);
        load(4'h4, 8'hA0); load(4'h5, 8'h10); load(4'h6, 8'h90); load(4'h7, 8'h60);
        load(4'h8, 8'hC3); load(4'h9, 8'hD0); load(4'hA, 8'hE0);
        in_port = 4'h9;
        run = 1;
        cyc(7);
        lit("addb_b", 8'(reg_b), m.b, 8'h01);
        lit("addb_carry", 8'(carry), m.c, 8'h01);
        cyc(2);
        lit("jnc_c1_pc", 8'(pc), m.pc, 8'h04);
        in_port = 4'h3;
        cyc(14);
        lit("mix_pc", 8'(pc), m.pc, 8'h00);
        lit("mix_a", 8'(reg_a), m.a, 8'h01);
        lit("mix_b", 8'(reg_b), m.b, 8'h03);
        lit("mix_out", 8'(out_port), m.out, 8'h01);
        run = 0;
        cyc(4);

        // Reset in the middle of EXEC
        do_reset();
        load(4'h0, 8'h77); load(4'h1, 8'h3F); load(4'h2, 8'hB5); load(4'h3, 8'h01);
        run = 1;
        cyc(7);
        lit("pre_rst_out", 8'(out_port), m.out, 8'h05);
        cyc(1);
        lit("pre_rst_state", 8'(state), m.phase, 8'h02);
        #1 rst_n = 1'b0;
        #1;
        lit("arst_state", 8'(state), m.phase, 8'h00);
        lit("arst_busy", 8'(busy), int'(m.phase != 0), 8'h00);
        lit("arst_pc", 8'(pc), m.pc, 8'h00);
        lit("arst_a", 8'(reg_a), m.a, 8'h00);
        lit("arst_b", 8'(reg_b), m.b, 8'h00);
        lit("arst_out", 8'(out_port), m.out, 8'h00);
        lit("arst_carry", 8'(carry), m.c, 8'h00);
        run = 0;
        cyc(1);
        rst_n = 1'b1;
        step = 1;
        cyc(1);
        step = 0;
        cyc(2);
        lit("mem_kept_b", 8'(reg_b), m.b, 8'h07);
        lit("mem_kept_pc", 8'(pc), m.pc, 8'h01);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
Parameters: none; data width fixed at 4 bits, program depth fixed at 16 words of 8 bits.
REQ-001 The block SHALL have these ports:
- clk0  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; execute instructions continuously while high
- step  in  1  one-cycle pulse; execute one instruction while run is low
- prog_we  in  1  program write strobe
- prog_addr  in  4  program write address
- prog_wdata  in  8  program write data: [7:4] opcode, [3:0] immediate
- in_port  in  4  external input operand
- out_port  out  4  OUT register
- pc  out  4  program counter
- reg_a  out  4  register A
- reg_b  out  4  register B
- carry  out  1  carry flag
- state  out  2  FSM state: IDLE=00, FETCH=01, EXEC=10
- busy  out  1  high when state is not IDLE

Function
REQ-002 The block SHALL hold a 16x8 program memory that rst_n does not clear.
REQ-003 A program write SHALL occur on a clk0 edge with prog_we=1 only in IDLE; prog_we SHALL be ignored in FETCH and EXEC.
REQ-004 IDLE SHALL go to FETCH when run=1 or step=1; run takes precedence; otherwise it SHALL stay in IDLE.
REQ-005 FETCH SHALL load IR from mem[pc] and then go to EXEC.
REQ-006 EXEC SHALL retire IR in one cycle, then go to FETCH if run=1, else to IDLE.
- Latency: exactly 2 cycles per instruction.
- A step pulse SHALL retire exactly one instruction.
REQ-007 The operand SHALL use the codebase selector encoding: 11=A, 10=B, 01=in_port, 00=zero.
- sum = operand + imm, 5 bits wide; result = sum[3:0]; cout = sum[4].
REQ-008 Opcodes:
- 0000 ADD A,Im: A<=A+Im
- 0001 MOV A,B: A<=B
- 0010 IN A: A<=in_port
- 0011 MOV A,Im: A<=Im
- 0100 MOV B,A: B<=A
- 0101 ADD B,Im: B<=B+Im
- 0110 IN B: B<=in_port
- 0111 MOV B,Im: B<=Im
- 1001 OUT B: out_port<=B
- 1011 OUT Im: out_port<=Im
- 1110 JNC Im: pc<=Im if carry=0
- 1111 JMP Im: pc<=Im
REQ-009 Opcodes 1000, 1010, 1100 and 1101 SHALL execute as NOP.
REQ-010 Every EXEC SHALL write carry: cout for ADD A and ADD B, 0 for all other opcodes.
REQ-011 JNC SHALL test the carry value held before its own EXEC.
REQ-012 Where no jump is taken, pc SHALL become pc+1 modulo 16, so 15 wraps to 0.
REQ-013 All registers SHALL update only on the EXEC edge and SHALL hold their values in IDLE and FETCH.
REQ-014 When prog_we and run are both high in IDLE, the write SHALL complete and FETCH entry SHALL occur on the same edge.
- A following FETCH of that address SHALL return the new word.

Reset
REQ-015 When rst_n=0, the block SHALL asynchronously set state=IDLE and pc, reg_a, reg_b, out_port, carry and IR to 0.
REQ-016 Reset during FETCH or EXEC SHALL abort the instruction with no register write; the aborted instruction SHALL not be re-executed.
REQ-017 The block SHALL hold IDLE and drive busy=0 from reset release until run or step is asserted.

Verification
REQ-018 Pulse rst_n low mid-EXEC -> immediately state=00, all outputs 0, busy=0; program memory intact.
REQ-019 Load {0:3F, 1:01, 2:E5, 3:B7} and hold run=1 -> after the ADD, A=0 and carry=1.
- JNC not taken, pc=3.
- Then out_port=7.
REQ-020 Load {0:31, 1:E4, 4:BA} and hold run=1 -> A=1, carry=0, JNC taken to pc=4, then out_port=A.
REQ-021 With run=0, pulse step once on the program of REQ-019 -> state goes 00->01->10->00.
- A=F, pc=1.
- No further change without another step.
REQ-022 Load {0:FF, F:00} and run -> pc=F, then the ADD A,0 at F wraps pc to 0; carry=0.
REQ-023 Assert prog_we to addr 0 with data 00 during EXEC -> memory unchanged.
- Same write in IDLE with run=1 -> the next fetch of addr 0 executes 00.
